xb_frame_sched: RTL and testbench



---
 rtl/xb_frame_sched.sv | 150 +++++++++++++++
 tb/tb_xb_frame_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xb_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : xb_frame_sched
// Brief   : Opcode-driven frame burst scheduler between Xillybus 32-bit FIFOs.
// Revision: 1.0  initial release
// ============================================================================
module xb_frame_sched #(
    parameter int CNT_W = 28,
    parameter int GAP_W = 16
) (
    input  logic             bus_clk,
    input  logic             reset,
    input  logic             cmd_empty,
    input  logic [31:0]      cmd_data,
    output logic             cmd_ack,
    input  logic             out_full,
    output logic             out_wren,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             eof,
    output logic [CNT_W-1:0] frames_left
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [3:0] c_OP_EOF     = 4'd0;
    localparam logic [3:0] c_OP_START   = 4'd1;
    localparam logic [3:0] c_OP_STOP    = 4'd2;
    localparam logic [3:0] c_OP_SET_GAP = 4'd3;
    localparam logic [3:0] c_OP_STATUS  = 4'd4;

    state_t           r_state;
    logic [CNT_W-1:0] r_seq;
    logic [CNT_W-1:0] r_frames_left;
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_resp_pend;
    logic [31:0]      r_resp;
    logic             r_cmd_ack;
    logic             r_eof;

    logic             w_accept;
    logic [3:0]       w_opcode;
    logic             w_resp_wr;
    logic             w_frame_wr;
    logic [27:0]      w_seq_ext;
    logic [31:0]      w_status;

    assign w_opcode  = cmd_data[31:28];
    // Ack low gates back-to-back reads of the same FWFT head word.
    assign w_accept  = !cmd_empty && !r_cmd_ack && !r_resp_pend;
    // Writes are qualified by reset so an aborted burst emits nothing further.
    assign w_resp_wr  = r_resp_pend && !out_full && !reset;
    assign w_frame_wr = (r_state == S_RUN) && !r_resp_pend && !out_full && !reset;
    assign w_seq_ext  = 28'(r_seq);
    assign w_status   = {4'hC, busy, r_eof, 10'b0, r_frames_left[15:0]};

    assign out_wren    = w_resp_wr || w_frame_wr;
    assign out_data    = w_resp_wr  ? r_resp :
                         w_frame_wr ? {4'h1, w_seq_ext} : 32'h0;
    assign cmd_ack     = r_cmd_ack;
    assign busy        = (r_state != S_IDLE);
    assign eof         = r_eof;
    assign frames_left = r_frames_left;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_seq         <= '0;
            r_frames_left <= '0;
            r_gap         <= '0;
            r_gap_cnt     <= '0;
            r_resp_pend   <= 1'b0;
            r_resp        <= '0;
            r_cmd_ack     <= 1'b0;
            r_eof         <= 1'b0;
        end else begin
            r_cmd_ack <= w_accept;
            if (w_resp_wr) begin
                r_resp_pend <= 1'b0;
            end

            case (r_state)
                S_RUN: begin
                    if (w_frame_wr) begin
                        r_seq         <= r_seq + CNT_W'(1);
                        r_frames_left <= r_frames_left - CNT_W'(1);
                        if (r_frames_left == CNT_W'(1)) begin
                            r_state <= S_IDLE;
                        end else if (r_gap != '0) begin
                            r_gap_cnt <= r_gap;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_W'(1)) begin
                        r_state <= S_RUN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: ;
            endcase

            // Decoded commands come last so they override same-cycle frame updates.
            if (w_accept) begin
                case (w_opcode)
                    c_OP_EOF: begin
                        r_eof         <= 1'b1;
                        r_frames_left <= '0;
                        r_state       <= S_IDLE;
                    end
                    c_OP_START: begin
                        if (cmd_data[CNT_W-1:0] == '0) begin
                            r_frames_left <= '0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_frames_left <= cmd_data[CNT_W-1:0];
                            r_seq         <= '0;
                            r_eof         <= 1'b0;
                            r_state       <= S_RUN;
                        end
                    end
                    c_OP_STOP: begin
                        r_frames_left <= '0;
                        r_state       <= S_IDLE;
                    end
                    c_OP_SET_GAP: begin
                        r_gap <= cmd_data[GAP_W-1:0];
                    end
                    c_OP_STATUS: begin
                        r_resp_pend <= 1'b1;
                        r_resp      <= w_status;
                    end
                    default: begin
                        r_resp_pend <= 1'b1;
                        r_resp      <= {4'hE, cmd_data[27:0]};
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xb_frame_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_xb_frame_sched
// Brief   : Directed and randomized self-checking bench for xb_frame_sched.
// Revision: 1.0  initial release
// ============================================================================
module tb_xb_frame_sched;
    localparam int CNT_W = 28;
    localparam int GAP_W = 16;
    localparam int MAXC  = 8192;

    logic             bus_clk = 1'b0;
    logic             reset;
    logic             cmd_empty;
    logic [31:0]      cmd_data;
    logic             cmd_ack;
    logic             out_full;
    logic             out_wren;
    logic [31:0]      out_data;
    logic             busy;
    logic             eof;
    logic [CNT_W-1:0] frames_left;

    xb_frame_sched #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
        .bus_clk     (bus_clk),
        .reset       (reset),
        .cmd_empty   (cmd_empty),
        .cmd_data    (cmd_data),
        .cmd_ack     (cmd_ack),
        .out_full    (out_full),
        .out_wren    (out_wren),
        .out_data    (out_data),
        .busy        (busy),
        .eof         (eof),
        .frames_left (frames_left)
    );

    always #5 bus_clk = ~bus_clk;

    logic [31:0]      cmd_q[$];
    int               wr_cyc[$];
    logic [31:0]      wr_dat[$];
    logic [31:0]      expv[$];
    logic             full_hist [MAXC];
    int               cyc_n, ack_cnt, viol, n_pass, n_tot;
    logic             s_ack, s_wren, s_busy, s_eof;
    logic [31:0]      s_data;
    logic [CNT_W-1:0] s_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tot++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, req);
    endtask

    function automatic int wc(input int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -1;
    endfunction

    task automatic refresh();
        cmd_empty = (cmd_q.size() == 0);
        cmd_data  = (cmd_q.size() == 0) ? 32'h0 : cmd_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        cmd_q.push_back(w);
        refresh();
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_dat.delete();
        expv.delete();
    endtask

    // Sample the current cycle mid-period, then advance to the next cycle and drive it.
    task automatic cyc(input logic full_nxt);
        @(negedge bus_clk);
        s_ack  = cmd_ack;
        s_wren = out_wren;
        s_data = out_data;
        s_busy = busy;
        s_eof  = eof;
        s_fl   = frames_left;
        if (out_wren) begin
            wr_cyc.push_back(cyc_n);
            wr_dat.push_back(out_data);
            if (out_full) viol++;
        end
        if (cmd_ack) ack_cnt++;
        @(posedge bus_clk);
        #1;
        if (s_ack && cmd_q.size() != 0) void'(cmd_q.pop_front());
        refresh();
        cyc_n++;
        out_full = full_nxt;
        if (cyc_n < MAXC) full_hist[cyc_n] = full_nxt;
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, wr_dat.size(), expv.size());
        for (int i = 0; i < expv.size() && i < wr_dat.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), wr_dat[i], expv[i]);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, a0, g, n, t;
        n_pass = 0; n_tot = 0; cyc_n = 0; ack_cnt = 0; viol = 0;
        for (int i = 0; i < MAXC; i++) full_hist[i] = 1'b0;
        reset = 1'b1; out_full = 1'b0;
        refresh();
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        chk("rst_cmd_ack", 32'(cmd_ack), 0);
        chk("rst_out_wren", 32'(out_wren), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eof", 32'(eof), 0);
        chk("rst_frames_left", 32'(frames_left), 0);
        @(posedge bus_clk);
        #1;
        reset = 1'b0;

        // START 3, no gap: three back-to-back frames.
        clear_log(); c0 = cyc_n; a0 = ack_cnt;
        push(32'h1000_0003);
        repeat (6) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
        chk_stream("burst3");
        chk("burst3_first_cyc", wc(0), c0 + 1);
        chk("burst3_last_cyc", wc(2), c0 + 3);
        chk("burst3_busy", 32'(s_busy), 0);
        chk("burst3_fl", 32'(s_fl), 0);
        chk("burst3_acks", ack_cnt - a0, 1);

        // SET_GAP 2 then START 2.
        clear_log(); c0 = cyc_n; a0 = ack_cnt;
        push(32'h3000_0002);
        push(32'h1000_0002);
        repeat (10) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001};
        chk_stream("gap2");
        chk("gap2_first_cyc", wc(0), c0 + 3);
        chk("gap2_spacing", wc(1) - wc(0), 3);
        chk("gap2_acks", ack_cnt - a0, 2);
        push(32'h3000_0000);
        repeat (3) cyc(1'b0);

        // START 4 with a 5-cycle full stall after the first frame.
        clear_log(); c0 = cyc_n;
        push(32'h1000_0004);
        cyc(1'b0);
        repeat (5) cyc(1'b1);
        repeat (8) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003};
        chk_stream("stall");
        chk("stall_resume_cyc", wc(1), c0 + 7);
        chk("stall_last_cyc", wc(3), c0 + 9);

        // STATUS after three frames, decoded while the output is full.
        clear_log();
        push(32'h1000_000A);
        repeat (3) cyc(1'b0);
        cyc(1'b1);
        push(32'h4000_0000);
        repeat (14) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002, 32'hC800_0007};
        for (int i = 3; i < 10; i++) expv.push_back(32'h1000_0000 + i);
        chk_stream("status");

        // Unknown opcode mid-burst: error word inserted, burst continues.
        clear_log();
        push(32'h1000_0006);
        repeat (2) cyc(1'b0);
        push(32'h7ABC_DEF0);
        repeat (12) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'hEABC_DEF0,
                32'h1000_0002, 32'h1000_0003, 32'h1000_0004, 32'h1000_0005};
        chk_stream("err_op");
        chk("err_op_busy", 32'(s_busy), 0);

        // EOF mid-burst.
        clear_log();
        push(32'h1000_0014);
        repeat (3) cyc(1'b0);
        push(32'h0000_0000);
        repeat (6) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
        chk_stream("eof_stop");
        chk("eof_flag", 32'(s_eof), 1);
        chk("eof_busy", 32'(s_busy), 0);
        chk("eof_fl", 32'(s_fl), 0);

        // Reset with five frames still to go, then a fresh single-frame burst.
        clear_log();
        push(32'h1000_0008);
        repeat (4) cyc(1'b0);
        reset = 1'b1;
        cyc(1'b0);
        chk("rstmid_fl_before", 32'(s_fl), 5);
        reset = 1'b0;
        cyc(1'b0);
        chk("rstmid_wren", 32'(s_wren), 0);
        chk("rstmid_data", s_data, 0);
        chk("rstmid_busy", 32'(s_busy), 0);
        chk("rstmid_eof", 32'(s_eof), 0);
        chk("rstmid_fl", 32'(s_fl), 0);
        chk("rstmid_ack", 32'(s_ack), 0);
        repeat (3) cyc(1'b0);
        expv = {32'h1000_0000, 32'h1000_0001, 32'h1000_0002};
        chk_stream("rstmid");
        clear_log();
        push(32'h1000_0001);
        repeat (4) cyc(1'b0);
        expv = {32'h1000_0000};
        chk_stream("restart");

        // Random bursts under random backpressure; write times derived from gap rule.
        for (int b = 0; b < 8; b++) begin
            g = $urandom_range(0, 4);
            n = $urandom_range(1, 12);
            clear_log(); c0 = cyc_n;
            push({4'h3, 12'h0, 16'(g)});
            push({4'h1, 28'(n)});
            t = 0;
            while (t < 800 && !(wr_dat.size() == n && s_busy == 1'b0)) begin
                cyc($urandom_range(0, 9) < 3);
                t++;
            end
            for (int i = 0; i < n; i++) expv.push_back(32'h1000_0000 + i);
            chk_stream($sformatf("rnd%0d", b));
            t = c0 + 3;
            for (int i = 0; i < n; i++) begin
                while (t < MAXC - 1 && full_hist[t]) t++;
                chk($sformatf("rnd%0d_cyc%0d", b, i), wc(i), t);
                t = t + 1 + g;
            end
            chk($sformatf("rnd%0d_fl", b), 32'(s_fl), 0);
        end

        chk("no_wren_when_full", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
